// File: rtl/hit_timestamp_fifo.sv
// Timestamps pin_capt hit strobes with a free-running coarse counter and epoch parity,
// and buffers hit and epoch-marker words in a first-word-fall-through FIFO.
module hit_timestamp_fifo #(
  parameter int unsigned COARSE_W = 12,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                         clk300,
  input  logic                         rst,
  input  logic                         str,
  input  logic [2:0]                   ptime,
  input  logic                         sync_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COARSE_W+4:0]          out_data,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int unsigned DATA_W  = COARSE_W + 5;
  localparam int unsigned EPOCH_W = DATA_W - 1;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;

  typedef enum logic [1:0] {WR_IDLE, WR_HIT, WR_MARKER} wr_sel_e;

  logic [COARSE_W-1:0] coarse_q;
  logic [EPOCH_W-1:0]  epoch_q;
  logic                wrap_q;
  logic                marker_pend_q;
  logic                hit_vld_q;
  logic [DATA_W-1:0]   hit_word_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]         rd_ptr_d;
  logic [LW-1:0]       level_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                overflow_q;
  logic [15:0]         drop_count_q;

  logic                wrap, full, rd_fire, room, hit_drop, wr_en, head_vis;
  wr_sel_e             wr_sel;
  logic [DATA_W-1:0]   wr_word;

  // Write arbitration: a registered hit always beats the pending marker.
  always_comb begin
    wrap     = (coarse_q == '1);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_fire  = out_valid_q & out_ready;
    room     = !full || rd_fire;
    wr_sel   = WR_IDLE;
    if (hit_vld_q) begin
      if (room) wr_sel = WR_HIT;
    end else if (marker_pend_q && room) begin
      wr_sel = WR_MARKER;
    end
    hit_drop = hit_vld_q && !room;
    wr_en    = (wr_sel != WR_IDLE);
    wr_word  = (wr_sel == WR_MARKER) ? {1'b1, epoch_q} : hit_word_q;
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
    // Only words written before this edge become visible at the output.
    head_vis = (rd_ptr_d != wr_ptr_q);
  end

  always_ff @(posedge clk300) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk300 or posedge rst) begin
    if (rst) begin
      coarse_q      <= '0;
      epoch_q       <= '0;
      wrap_q        <= 1'b0;
      marker_pend_q <= 1'b0;
      hit_vld_q     <= 1'b0;
      hit_word_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      hit_vld_q <= str;
      if (str) hit_word_q <= {1'b0, epoch_q[0], coarse_q, ptime};

      coarse_q <= sync_in ? '0 : coarse_q + COARSE_W'(1);
      if (sync_in)   epoch_q <= '0;
      else if (wrap) epoch_q <= epoch_q + EPOCH_W'(1);
      wrap_q <= wrap && !sync_in;

      // Marker becomes eligible one cycle after the wrap, behind the hit pipeline.
      if (sync_in)                    marker_pend_q <= 1'b0;
      else if (wrap_q)                marker_pend_q <= 1'b1;
      else if (wr_sel == WR_MARKER)   marker_pend_q <= 1'b0;

      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      rd_ptr_q <= rd_ptr_d;
      if (wr_en && !rd_fire)      level_q <= level_q + LW'(1);
      else if (!wr_en && rd_fire) level_q <= level_q - LW'(1);

      out_valid_q <= head_vis;
      if (head_vis) out_data_q <= mem_q[rd_ptr_d[AW-1:0]];

      if (hit_drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_hit_timestamp_fifo.sv
// Bench for hit_timestamp_fifo: directed timing scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_hit_timestamp_fifo;

  localparam int COARSE_W = 12;
  localparam int DEPTH    = 16;
  localparam int CMAX     = (1 << COARSE_W) - 1;

  logic        clk300 = 1'b0;
  logic        rst = 1'b1;
  logic        str = 1'b0;
  logic [2:0]  ptime = 3'd0;
  logic        sync_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [16:0] out_data;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  hit_timestamp_fifo #(.COARSE_W(COARSE_W), .DEPTH(DEPTH)) dut (
    .clk300(clk300), .rst(rst), .str(str), .ptime(ptime), .sync_in(sync_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk300 = ~clk300;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counters as integers, FIFO as a queue of words.
  int          m_coarse = 0;
  int          m_epoch = 0;
  bit          m_hit_p = 0;
  logic [16:0] m_hit_w = '0;
  bit          m_mk_req = 0;
  bit          m_mk_pend = 0;
  logic [16:0] m_q[$];
  bit          m_valid = 0;
  logic [16:0] m_data = '0;
  int          m_drops = 0;
  bit          m_ovf = 0;

  always @(posedge clk300 or posedge rst) begin
    int vis;
    if (rst) begin
      m_coarse = 0; m_epoch = 0; m_hit_p = 0; m_hit_w = '0;
      m_mk_req = 0; m_mk_pend = 0; m_q.delete();
      m_valid = 0; m_data = '0; m_drops = 0; m_ovf = 0;
    end else begin
      if (m_valid && out_ready) void'(m_q.pop_front());
      vis = m_q.size();
      if (m_hit_p) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_hit_w);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end else if (m_mk_pend && m_q.size() < DEPTH) begin
        m_q.push_back({1'b1, 16'(m_epoch)});
        m_mk_pend = 0;
      end
      m_valid = (vis > 0);
      if (m_valid) m_data = m_q[0];
      if (m_mk_req) m_mk_pend = 1;
      m_hit_p = str;
      if (str) m_hit_w = {1'b0, 1'(m_epoch % 2), 12'(m_coarse), ptime};
      if (sync_in) begin
        m_coarse = 0; m_epoch = 0; m_mk_req = 0; m_mk_pend = 0;
      end else if (m_coarse == CMAX) begin
        m_coarse = 0; m_epoch = (m_epoch + 1) % 65536; m_mk_req = 1;
      end else begin
        m_coarse++; m_mk_req = 0;
      end
    end
  end

  always @(negedge clk300) begin
    if (chk_en && !rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk300);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; str = 1'b0; sync_in = 1'b0; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    int th;
    // Reset values, then one hit at coarse=10 with latency 2
    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drops", 32'(drop_count), 0);
    step(10);
    str = 1'b1; ptime = 3'd5;
    step(1);
    str = 1'b0;
    step(1);
    chk("t1_valid_k1", 32'(out_valid), 0);
    step(1);
    chk("t1_valid_k2", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), (10 << 3) | 5);

    // 17 hits into a 16-deep FIFO with no reads
    do_reset();
    for (int i = 0; i < 17; i++) begin
      str = 1'b1; ptime = 3'((i + 3) % 8);
      step(1);
    end
    str = 1'b0;
    step(3);
    chk("t2_level", 32'(fifo_level), 16);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_drops", 32'(drop_count), 1);
    chk("t2_head", 32'(out_data), 3);

    // Drain to 7 words, then async reset mid-cycle
    out_ready = 1'b1;
    step(9);
    out_ready = 1'b0;
    chk("t6_level7", 32'(fifo_level), 7);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_drops", 32'(drop_count), 0);
    step(1);
    rst = 1'b0;

    // Hit on coarse max, hit on coarse 0, then epoch marker
    do_reset();
    step(CMAX);
    str = 1'b1; ptime = 3'd1;
    step(1);
    ptime = 3'd6;
    step(1);
    str = 1'b0;
    step(4);
    chk("t3_level", 32'(fifo_level), 3);
    chk("t3_hit_max", 32'(out_data), (CMAX << 3) | 1);
    pop_one();
    chk("t4_hit_c0", 32'(out_data), (1 << 15) | 6);
    pop_one();
    chk("t3_marker", 32'(out_data), (1 << 16) | 1);

    // sync_in coincident with a hit at coarse=300
    do_reset();
    step(300);
    str = 1'b1; ptime = 3'd2; sync_in = 1'b1;
    step(1);
    str = 1'b0; sync_in = 1'b0;
    step(2);
    str = 1'b1; ptime = 3'd7;
    step(1);
    str = 1'b0;
    step(3);
    chk("t5_level", 32'(fifo_level), 2);
    chk("t5_hit_sync", 32'(out_data), (300 << 3) | 2);
    pop_one();
    chk("t5_hit_after", 32'(out_data), (2 << 3) | 7);

    // Random traffic with varying read pressure
    do_reset();
    for (int i = 0; i < 9000; i++) begin
      th = (i / 1500) % 4;
      str = 1'($urandom_range(0, 1));
      ptime = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) < th);
      sync_in = ($urandom_range(0, 1999) == 0);
      step(1);
    end
    str = 1'b0; sync_in = 1'b0; out_ready = 1'b1;
    step(DEPTH + 4);
    chk("final_level", 32'(fifo_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
